// File: rtl/sq_frame_accumulator.sv
// sq_frame_accumulator: sums FRAME_LEN squared samples into one frame energy.
// Samples arrive over a valid/ready handshake. Each finished frame is held on a
// registered output until downstream takes it. Sums saturate at all-ones, and
// sum_ovf marks any frame that saturated.
module sq_frame_accumulator #(
   parameter int SQ_W      = 16,
   parameter int FRAME_LEN = 4,
   parameter int ACC_W     = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [SQ_W-1:0]  sq_in,
   input  logic             sq_valid,
   output logic             sq_ready,
   output logic [ACC_W-1:0] sum_out,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic             sum_ovf,
   output logic [7:0]       sample_cnt
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   // Index of the final sample in a frame. sample_cnt is 8 bits, which covers FRAME_LEN up to 256.
   localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);
   // Zero bits needed to widen sq_in to ACC_W+1. The extra top bit catches the carry.
   localparam int EXT_W = ACC_W + 1 - SQ_W;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [ACC_W-1:0] sum_out_q, sum_out_d;
   logic             sum_ovf_q, sum_ovf_d;
   logic             sum_valid_q, sum_valid_d;

   logic             accept;
   logic             last_sample;
   logic             out_take;
   logic [ACC_W:0]   sq_ext;
   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] sum_sat;
   logic             add_ovf;

   // Clamp a carry-extended sum to the accumulator range instead of wrapping.
   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
      if (s[ACC_W])
         return '1;
      return s[ACC_W-1:0];
   endfunction

   assign accept      = sq_valid & sq_ready;
   assign last_sample = (cnt_q == LAST_CNT);
   assign out_take    = sum_valid_q & sum_ready;
   assign sq_ext      = {{EXT_W{1'b0}}, sq_in};
   assign sum_wide    = {1'b0, acc_q} + sq_ext;
   assign add_ovf     = sum_wide[ACC_W];
   assign sum_sat     = sat_acc(sum_wide);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ACCUM;
      else
         state_q <= state_d;
   end

   // Next state: leave ACCUM on the last accepted sample; leave HOLD once the frame is consumed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (accept && last_sample) state_d = HOLD;
         HOLD:    if (out_take)              state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   // FSM outputs: take samples only while accumulating, and never on a clear cycle.
   always_comb begin
      sq_ready = 1'b0;
      if (state_q == ACCUM && !clear)
         sq_ready = 1'b1;
   end

   // Datapath next state: accumulate, close the frame, abort on clear, release on handshake.
   always_comb begin
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      sum_out_d   = sum_out_q;
      sum_ovf_d   = sum_ovf_q;
      sum_valid_d = sum_valid_q;
      if (state_q == ACCUM) begin
         if (clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
         end else if (accept) begin
            if (last_sample) begin
               sum_out_d   = sum_sat;
               sum_ovf_d   = ovf_q | add_ovf;
               sum_valid_d = 1'b1;
               acc_d       = '0;
               ovf_d       = 1'b0;
               cnt_d       = '0;
            end else begin
               acc_d = sum_sat;
               ovf_d = ovf_q | add_ovf;
               cnt_d = cnt_q + 8'd1;
            end
         end
      end else if (out_take) begin
         sum_valid_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         sum_out_q   <= '0;
         sum_ovf_q   <= 1'b0;
         sum_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         sum_out_q   <= sum_out_d;
         sum_ovf_q   <= sum_ovf_d;
         sum_valid_q <= sum_valid_d;
      end
   end

   assign sum_out    = sum_out_q;
   assign sum_ovf    = sum_ovf_q;
   assign sum_valid  = sum_valid_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sq_frame_accumulator.sv
// Bench for sq_frame_accumulator. It runs two instances in lockstep: the
// default ACC_W=18 and ACC_W=16. A negedge scoreboard predicts every frame
// from the true sum of the accepted samples.
module tb_sq_frame_accumulator;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic [15:0] sq_in;
   logic        sq_valid;
   logic        sum_ready;

   logic        rdy18, vld18, ovf18;
   logic [17:0] sum18;
   logic [7:0]  cnt18;
   logic        rdy16, vld16, ovf16;
   logic [15:0] sum16;
   logic [7:0]  cnt16;

   int n_vec = 0;
   int n_err = 0;

   // scoreboard model state
   bit          mon_en = 0;
   bit          m_hold = 0;
   int          m_cnt  = 0;
   longint      m_sum  = 0;
   logic [17:0] q_s18[$];
   logic        q_o18[$];
   logic [15:0] q_s16[$];
   logic        q_o16[$];

   sq_frame_accumulator u18 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .sq_in(sq_in), .sq_valid(sq_valid),
      .sq_ready(rdy18), .sum_out(sum18), .sum_valid(vld18), .sum_ready(sum_ready),
      .sum_ovf(ovf18), .sample_cnt(cnt18)
   );

   sq_frame_accumulator #(.SQ_W(16), .FRAME_LEN(4), .ACC_W(16)) u16 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .sq_in(sq_in), .sq_valid(sq_valid),
      .sq_ready(rdy16), .sum_out(sum16), .sum_valid(vld16), .sum_ready(sum_ready),
      .sum_ovf(ovf16), .sample_cnt(cnt16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: compare the handshake with the model, pop expected frames on
   // delivery, and push a new expectation when a frame completes.
   always @(negedge clk) begin
      logic        exp_rdy;
      logic [17:0] e18;
      logic [15:0] e16;
      logic        eo18, eo16;
      if (!rst_n) begin
         m_hold = 0; m_cnt = 0; m_sum = 0; mon_en = 1;
         q_s18.delete(); q_o18.delete(); q_s16.delete(); q_o16.delete();
      end else if (mon_en) begin
         exp_rdy = !m_hold && !clear;
         n_vec++;
         if (rdy18 !== exp_rdy || rdy16 !== exp_rdy) begin
            n_err++;
            $display("FAIL sq_ready: got %b/%b expected %b", rdy18, rdy16, exp_rdy);
         end
         n_vec++;
         if (vld18 !== m_hold || vld16 !== m_hold) begin
            n_err++;
            $display("FAIL sum_valid: got %b/%b expected %b", vld18, vld16, m_hold);
         end
         n_vec++;
         if (cnt18 !== 8'(m_cnt) || cnt16 !== 8'(m_cnt)) begin
            n_err++;
            $display("FAIL sample_cnt: got %0d/%0d expected %0d", cnt18, cnt16, m_cnt);
         end
         if (m_hold && sum_ready) begin
            n_vec++;
            if (q_s18.size() == 0) begin
               n_err++;
               $display("FAIL sb_frame: got delivery expected none queued");
            end else begin
               e18 = q_s18.pop_front(); eo18 = q_o18.pop_front();
               e16 = q_s16.pop_front(); eo16 = q_o16.pop_front();
               if (sum18 !== e18 || ovf18 !== eo18) begin
                  n_err++;
                  $display("FAIL sb_sum18: got %0d ovf %b expected %0d ovf %b", sum18, ovf18, e18, eo18);
               end
               n_vec++;
               if (sum16 !== e16 || ovf16 !== eo16) begin
                  n_err++;
                  $display("FAIL sb_sum16: got %0d ovf %b expected %0d ovf %b", sum16, ovf16, e16, eo16);
               end
            end
            m_hold = 0;
         end else if (exp_rdy && sq_valid) begin
            m_sum += longint'(sq_in);
            m_cnt++;
            if (m_cnt == 4) begin
               q_s18.push_back((m_sum > 262143) ? 18'h3FFFF : 18'(m_sum));
               q_o18.push_back(m_sum > 262143);
               q_s16.push_back((m_sum > 65535) ? 16'hFFFF : 16'(m_sum));
               q_o16.push_back(m_sum > 65535);
               m_hold = 1; m_cnt = 0; m_sum = 0;
            end
         end else if (clear && !m_hold) begin
            m_cnt = 0; m_sum = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Offer one sample and wait (bounded) until it is accepted.
   task automatic send(input logic [15:0] v);
      logic rdy;
      rdy = 1'b0;
      sq_valid = 1'b1;
      sq_in    = v;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         rdy = rdy18;
         step();
         if (rdy) break;
      end
      n_vec++;
      if (!rdy) begin
         n_err++;
         $display("FAIL send_timeout: got no accept expected accept of %0d", v);
      end
   endtask

   task automatic idle(input int n);
      sq_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      n_vec++;
      if (sum18 !== 18'd0 || vld18 !== 1'b0 || ovf18 !== 1'b0 || cnt18 !== 8'd0 ||
          sum16 !== 16'd0 || vld16 !== 1'b0 || ovf16 !== 1'b0 || cnt16 !== 8'd0) begin
         n_err++;
         $display("FAIL reset_state: got sum %0d vld %b ovf %b cnt %0d expected all 0", sum18, vld18, ovf18, cnt18);
      end
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (rdy18 !== 1'b1 || rdy16 !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b/%b expected 1", rdy18, rdy16);
      end
   endtask

   task automatic test_basic();
      sum_ready = 1'b1;
      send(16'd0); send(16'd4); send(16'd16); send(16'd36);
      sq_valid = 1'b0;
      n_vec++;
      if (vld18 !== 1'b1 || sum18 !== 18'd56 || ovf18 !== 1'b0) begin
         n_err++;
         $display("FAIL basic_sum: got vld %b sum %0d ovf %b expected 1 56 0", vld18, sum18, ovf18);
      end
      step();
      n_vec++;
      if (vld18 !== 1'b0 || rdy18 !== 1'b1) begin
         n_err++;
         $display("FAIL basic_release: got vld %b rdy %b expected 0 1", vld18, rdy18);
      end
      idle(1);
   endtask

   task automatic test_max();
      repeat (4) send(16'd65025);
      sq_valid = 1'b0;
      n_vec++;
      if (sum18 !== 18'd260100 || ovf18 !== 1'b0) begin
         n_err++;
         $display("FAIL max_sum18: got %0d ovf %b expected 260100 0", sum18, ovf18);
      end
      idle(2);
   endtask

   task automatic test_saturation();
      send(16'd65025); send(16'd65025); send(16'd1); send(16'd1);
      sq_valid = 1'b0;
      n_vec++;
      if (sum16 !== 16'd65535 || ovf16 !== 1'b1) begin
         n_err++;
         $display("FAIL sat_sum16: got %0d ovf %b expected 65535 1", sum16, ovf16);
      end
      n_vec++;
      if (sum18 !== 18'd130052 || ovf18 !== 1'b0) begin
         n_err++;
         $display("FAIL sat_sum18: got %0d ovf %b expected 130052 0", sum18, ovf18);
      end
      idle(1);
      repeat (4) send(16'd1);
      sq_valid = 1'b0;
      n_vec++;
      if (sum16 !== 16'd4 || ovf16 !== 1'b0) begin
         n_err++;
         $display("FAIL sat_next16: got %0d ovf %b expected 4 0", sum16, ovf16);
      end
      idle(2);
   endtask

   task automatic test_backpressure();
      sum_ready = 1'b0;
      send(16'd1); send(16'd2); send(16'd3); send(16'd4);
      sq_in = 16'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++;
         if (sum18 !== 18'd10 || vld18 !== 1'b1 || rdy18 !== 1'b0 || cnt18 !== 8'd0) begin
            n_err++;
            $display("FAIL hold_stable: got sum %0d vld %b rdy %b cnt %0d expected 10 1 0 0",
                     sum18, vld18, rdy18, cnt18);
         end
      end
      sum_ready = 1'b1;
      step();
      n_vec++;
      if (vld18 !== 1'b0 || rdy18 !== 1'b1) begin
         n_err++;
         $display("FAIL hold_release: got vld %b rdy %b expected 0 1", vld18, rdy18);
      end
      repeat (4) send(16'd9);
      sq_valid = 1'b0;
      n_vec++;
      if (sum18 !== 18'd36 || vld18 !== 1'b1) begin
         n_err++;
         $display("FAIL hold_next: got %0d vld %b expected 36 1", sum18, vld18);
      end
      idle(2);
   endtask

   task automatic test_clear();
      send(16'd100); send(16'd200);
      clear    = 1'b1;
      sq_valid = 1'b1;
      sq_in    = 16'd77;
      @(negedge clk);
      n_vec++;
      if (rdy18 !== 1'b0) begin
         n_err++;
         $display("FAIL clear_ready: got %b expected 0", rdy18);
      end
      step();
      clear = 1'b0;
      n_vec++;
      if (cnt18 !== 8'd0) begin
         n_err++;
         $display("FAIL clear_cnt: got %0d expected 0", cnt18);
      end
      send(16'd5); send(16'd6); send(16'd7); send(16'd8);
      sq_valid = 1'b0;
      n_vec++;
      if (sum18 !== 18'd26) begin
         n_err++;
         $display("FAIL clear_sum: got %0d expected 26", sum18);
      end
      idle(2);
   endtask

   task automatic test_gaps();
      send(16'd3); idle(2);
      send(16'd4); idle(1);
      n_vec++;
      if (cnt18 !== 8'd2) begin
         n_err++;
         $display("FAIL gap_cnt: got %0d expected 2", cnt18);
      end
      send(16'd5); idle(3);
      send(16'd6);
      sq_valid = 1'b0;
      n_vec++;
      if (sum18 !== 18'd18) begin
         n_err++;
         $display("FAIL gap_sum: got %0d expected 18", sum18);
      end
      idle(2);
   endtask

   task automatic test_reset_mid();
      send(16'd1); send(16'd1);
      sq_valid = 1'b0;
      n_vec++;
      if (cnt18 !== 8'd2) begin
         n_err++;
         $display("FAIL mid_cnt: got %0d expected 2", cnt18);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_vec++;
      if (cnt18 !== 8'd0 || vld18 !== 1'b0 || sum18 !== 18'd0) begin
         n_err++;
         $display("FAIL mid_reset: got cnt %0d vld %b sum %0d expected 0 0 0", cnt18, vld18, sum18);
      end
      sum_ready = 1'b0;
      repeat (4) send(16'd2);
      sq_valid = 1'b0;
      step();
      n_vec++;
      if (vld18 !== 1'b1 || sum18 !== 18'd8) begin
         n_err++;
         $display("FAIL hold_before_reset: got vld %b sum %0d expected 1 8", vld18, sum18);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (vld18 !== 1'b0 || sum18 !== 18'd0 || ovf18 !== 1'b0 || cnt18 !== 8'd0 || rdy18 !== 1'b1 ||
          vld16 !== 1'b0 || sum16 !== 16'd0) begin
         n_err++;
         $display("FAIL hold_reset: got vld %b sum %0d ovf %b cnt %0d rdy %b expected 0 0 0 0 1",
                  vld18, sum18, ovf18, cnt18, rdy18);
      end
      sum_ready = 1'b1;
      repeat (4) send(16'd1);
      sq_valid = 1'b0;
      n_vec++;
      if (sum18 !== 18'd4 || ovf18 !== 1'b0) begin
         n_err++;
         $display("FAIL after_reset_sum: got %0d ovf %b expected 4 0", sum18, ovf18);
      end
      idle(3);
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      sq_in     = '0;
      sq_valid  = 1'b0;
      sum_ready = 1'b0;
      test_reset();
      test_basic();
      test_max();
      test_saturation();
      test_backpressure();
      test_clear();
      test_gaps();
      test_reset_mid();
      n_vec++;
      if (q_s18.size() != 0 || m_hold) begin
         n_err++;
         $display("FAIL drain: got %0d frames pending expected 0", q_s18.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sq_frame_accumulator.md
Name: sq_frame_accumulator

Overview:
- Downstream consumer of the combinational 8-bit squarer (n_bit_square, 16-bit result).
- Accepts a stream of squared samples over a valid/ready handshake and sums FRAME_LEN of them into a frame energy (sum of squares).
- Presents each frame sum on a registered output with its own valid/ready handshake.
- Saturates on overflow and flags it per frame.

Parameters:
- SQ_W, 16, width of incoming square (2 × 8-bit operand width).
- FRAME_LEN, 4, samples per frame; legal range 2..256.
- ACC_W, 18, accumulator/output width; SQ_W + clog2(FRAME_LEN) guarantees no saturation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous frame abort; discards partial sum.
- sq_in  input  SQ_W  squared sample from the squarer.
- sq_valid  input  1  sq_in is valid this cycle.
- sq_ready  output  1  block accepts a sample this cycle.
- sum_out  output  ACC_W  completed frame sum, registered.
- sum_valid  output  1  sum_out holds an unconsumed frame.
- sum_ready  input  1  downstream accepts sum_out.
- sum_ovf  output  1  frame sum was saturated; qualified by sum_valid.
- sample_cnt  output  8  samples accepted in the current frame.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to ACCUM.
  - acc, sum_out, sample_cnt = 0; sum_valid = 0; sum_ovf = 0.
  - sq_ready = 1 from the first cycle after reset.
  - Reset overrides clear and all handshakes.
- States: ACCUM, HOLD.
- ACCUM:
  - sq_ready = 1. Accept when sq_valid & sq_ready.
  - On accept, acc <= sat(acc + zero-extended sq_in) and sample_cnt increments.
  - Saturation: if the true sum exceeds 2^ACC_W − 1, acc holds all-ones and the internal ovf bit is set for the rest of the frame.
  - On the accept where sample_cnt == FRAME_LEN−1:
    - sum_out <= saturated final sum; sum_ovf <= ovf | this add's overflow.
    - sum_valid <= 1; acc, ovf, sample_cnt <= 0; next state HOLD.
  - Latency: sum_valid rises the cycle after the last sample is accepted.
- HOLD:
  - sq_ready = 0; upstream must hold its sample.
  - sum_out, sum_ovf and sum_valid stay stable until handshake.
  - On sum_valid & sum_ready: sum_valid <= 0, next state ACCUM; sq_ready is 1 the following cycle.
  - Zero-bubble overlap is not supported; minimum frame period is FRAME_LEN + 1 cycles when sum_ready is held high.
- clear:
  - In ACCUM: acc, ovf, sample_cnt <= 0. A sample offered the same cycle is not accepted, and sq_ready is driven 0 that cycle.
  - In HOLD: no effect; the completed frame is still delivered.
- sq_valid = 0 cycles:
  - Gaps are allowed anywhere in a frame; acc and sample_cnt hold.
- Arithmetic:
  - Unsigned throughout; sq_in is zero-extended to ACC_W+1 for the overflow check.
  - sum_out is never wrapped.
- sample_cnt:
  - Counts 0..FRAME_LEN−1 and reads 0 in HOLD.

Test Plan:
- Reset, then samples 0, 4, 16, 36 (squares of 0, 2, 4, 6) on consecutive cycles, sum_ready=1 → sum_valid one cycle after the 4th accept; sum_out = 56, sum_ovf = 0; sq_ready = 1 two cycles later.
- Four samples of 65025 (255²) with default ACC_W → sum_out = 260100, sum_ovf = 0.
- ACC_W=16, samples 65025, 65025, 1, 1 → sum_out = 65535, sum_ovf = 1. The next frame of 1, 1, 1, 1 gives sum_out = 4, sum_ovf = 0 (flag not sticky across frames).
- Frame 1, 2, 3, 4 completes with sum_ready = 0 for 5 cycles while sq_valid = 1, sq_in = 9:
  - sum_out = 10 held, sq_ready = 0, no sample consumed.
  - After sum_ready pulse, next frame 9, 9, 9, 9 → 36.
- Accept 100, 200, assert clear, then 5, 6, 7, 8 → sum_out = 26. A sample offered during the clear cycle is not counted (sample_cnt = 0 after clear).
- rst_n low mid-frame (after 2 accepts) and again in HOLD → all outputs 0, sum_valid = 0, the next 4 samples 1, 1, 1, 1 give sum_out = 4.
